spi_slave_core: RTL and testbench

Synthesisable, parametrised SPI slave for the SPI subsystem. It receives the master's sclk, mosi and slave-select lines and oversamples them on the system clock. Configurable character length, bit order and independent tx/rx sampling edges match the spi_top control-register modes. Parallel TX/RX words move over valid/ready handshakes with one-entry buffering, plus overrun and underrun flags.

---
 rtl/spi_slave_pkg.sv | 30 +++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_core.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_core.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types, constants and helpers for the SPI slave core.
package spi_slave_pkg;

  // Character FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  // Values of cfg_tx_neg / cfg_rx_neg selecting the active sclk edge
  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // Working width for character-length arithmetic
  localparam int LEN_W = 16;

  // Effective character length: a programmed length of zero means the widest character
  function automatic logic [LEN_W-1:0] len_eff(input logic [LEN_W-1:0] char_len,
                                               input logic [LEN_W-1:0] max_len);
    logic [LEN_W-1:0] v_len;
    if (char_len == {LEN_W{1'b0}}) begin
      v_len = max_len;
    end else begin
      v_len = char_len;
    end
    return v_len;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous line plus rise/fall detection
// taken from the last two synchronised samples.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  // Synchroniser chain plus one extra history flop for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= w_level;
    end
  end

  assign o_rise = w_level & ~r_prev;
  assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave: oversampled sclk/mosi/ss, programmable character length, bit
// order and sampling edges, one-entry TX/RX buffering with handshakes.
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int MAX_CHAR_LEN = 32,
  parameter int SS_WIDTH     = 8,
  parameter int SS_INDEX     = 0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                            wb_clk_in,
  input  logic                            wb_rst_in,
  input  logic                            sclk_in,
  input  logic                            mosi_in,
  input  logic [SS_WIDTH-1:0]             ss_pad_in,
  output logic                            miso_out,
  output logic                            miso_oe,
  input  logic [$clog2(MAX_CHAR_LEN)-1:0] cfg_char_len,
  input  logic                            cfg_lsb,
  input  logic                            cfg_tx_neg,
  input  logic                            cfg_rx_neg,
  input  logic [MAX_CHAR_LEN-1:0]         tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic [MAX_CHAR_LEN-1:0]         rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic                            overrun,
  output logic                            underrun,
  output logic                            busy
);

  localparam int PTR_W = $clog2(MAX_CHAR_LEN);
  localparam int CNT_W = $clog2(MAX_CHAR_LEN + 1);

  logic                    w_sclk_rise, w_sclk_fall;
  logic [SYNC_STAGES-1:0]  r_mosi_sync, r_sel_sync;
  logic                    w_mosi, w_sel, w_ss_unused;
  state_e                  r_state;
  logic [MAX_CHAR_LEN-1:0] r_tx_hold, r_tx_shift, r_rx_shift, r_rx_data;
  logic [MAX_CHAR_LEN-1:0] w_rx_next, w_load_word;
  logic                    r_tx_ready, r_rx_valid, r_overrun, r_underrun;
  logic                    r_busy, r_miso, r_miso_oe;
  logic                    r_lsb, r_tx_neg, r_rx_neg;
  logic [PTR_W-1:0]        r_ptr, w_ptr_adv, w_start_ptr, w_rx_pos;
  logic [CNT_W-1:0]        r_rx_cnt, r_len, w_len_cfg;
  logic                    w_rx_edge, w_tx_edge, w_done, w_tx_adv;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .i_clk   (wb_clk_in),
    .i_rst_n (wb_rst_in),
    .i_d     (sclk_in),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // Only our own select bit matters; the rest of the bus is ignored
  assign w_ss_unused = ^ss_pad_in;
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sel       = r_sel_sync[SYNC_STAGES-1];

  // Synchronise mosi and the (inverted, so reset reads as deselected) select line
  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_in) begin
      r_mosi_sync <= {SYNC_STAGES{1'b0}};
      r_sel_sync  <= {SYNC_STAGES{1'b0}};
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
      r_sel_sync  <= {r_sel_sync[SYNC_STAGES-2:0], ~ss_pad_in[SS_INDEX]};
    end
  end

  // Edge decode, bit positions and load-time values for the current character
  always_comb begin
    w_rx_edge   = (r_rx_neg == EDGE_FALL) ? w_sclk_fall : w_sclk_rise;
    w_tx_edge   = (r_tx_neg == EDGE_FALL) ? w_sclk_fall : w_sclk_rise;
    w_done      = (r_state == SHIFT) && w_rx_edge && (r_rx_cnt == (r_len - CNT_W'(1)));
    // Sample happens before shift-out, so a shared edge on the first bit still advances
    w_tx_adv    = (r_state == SHIFT) && w_tx_edge &&
                  ((r_rx_cnt != {CNT_W{1'b0}}) || w_rx_edge) && !w_done;
    w_ptr_adv   = r_lsb ? (r_ptr + PTR_W'(1)) : (r_ptr - PTR_W'(1));
    w_rx_pos    = r_lsb ? PTR_W'(r_rx_cnt) : PTR_W'(r_len - CNT_W'(1) - r_rx_cnt);
    w_rx_next   = r_rx_shift;
    w_rx_next[w_rx_pos] = w_mosi;
    w_len_cfg   = CNT_W'(len_eff(LEN_W'(cfg_char_len), LEN_W'(MAX_CHAR_LEN)));
    w_start_ptr = cfg_lsb ? {PTR_W{1'b0}} : PTR_W'(w_len_cfg - CNT_W'(1));
    w_load_word = r_tx_ready ? {MAX_CHAR_LEN{1'b0}} : r_tx_hold;
  end

  // Character FSM with TX/RX buffering, handshakes and status pulses
  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_in) begin
      r_state    <= IDLE;
      r_tx_hold  <= {MAX_CHAR_LEN{1'b0}};
      r_tx_shift <= {MAX_CHAR_LEN{1'b0}};
      r_rx_shift <= {MAX_CHAR_LEN{1'b0}};
      r_rx_data  <= {MAX_CHAR_LEN{1'b0}};
      r_tx_ready <= 1'b1;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_lsb      <= 1'b0;
      r_tx_neg   <= 1'b0;
      r_rx_neg   <= 1'b0;
      r_ptr      <= {PTR_W{1'b0}};
      r_rx_cnt   <= {CNT_W{1'b0}};
      r_len      <= {CNT_W{1'b0}};
    end else begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      // Accept and consume are exclusive: one needs the holding register empty, the other full
      if (tx_valid && r_tx_ready) begin
        r_tx_hold  <= tx_data;
        r_tx_ready <= 1'b0;
      end
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (!w_sel) begin
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_miso_oe <= 1'b0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= LOAD;
          end
          LOAD: begin
            r_lsb      <= cfg_lsb;
            r_tx_neg   <= cfg_tx_neg;
            r_rx_neg   <= cfg_rx_neg;
            r_len      <= w_len_cfg;
            r_ptr      <= w_start_ptr;
            r_rx_cnt   <= {CNT_W{1'b0}};
            r_rx_shift <= {MAX_CHAR_LEN{1'b0}};
            r_tx_shift <= w_load_word;
            r_miso     <= w_load_word[w_start_ptr];
            r_busy     <= 1'b1;
            r_miso_oe  <= 1'b1;
            if (!r_tx_ready) begin
              r_tx_ready <= 1'b1;
            end else begin
              r_underrun <= 1'b1;
            end
            r_state <= SHIFT;
          end
          SHIFT: begin
            if (w_rx_edge) begin
              r_rx_shift <= w_rx_next;
              r_rx_cnt   <= r_rx_cnt + CNT_W'(1);
            end
            if (w_tx_adv) begin
              r_ptr  <= w_ptr_adv;
              r_miso <= r_tx_shift[w_ptr_adv];
            end
            if (w_done) begin
              if (!r_rx_valid || rx_ready) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              r_state <= LOAD;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign miso_out = r_miso;
  assign miso_oe  = r_miso_oe;
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign overrun  = r_overrun;
  assign underrun = r_underrun;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_slave_core.sv
// Scoreboard bench for spi_slave_core: a behavioural SPI master drives
// characters, expected RX words are queued at stimulus time and compared
// against words the consumer side accepts.
module tb_spi_slave_core;

  localparam int H    = 8;   // master half-period in wb clocks
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic [7:0]  ss = 8'hFF;
  logic        miso_out, miso_oe;
  logic [4:0]  cfg_char_len = 5'd4;
  logic        cfg_lsb = 1'b1, cfg_tx_neg = 1'b0, cfg_rx_neg = 1'b1;
  logic [31:0] tx_data = 32'h0;
  logic        tx_valid = 1'b0, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ready = 1'b0;
  logic        overrun, underrun, busy;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_under = 0;
  int          n_over = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  spi_slave_core #(.MAX_CHAR_LEN(32), .SS_WIDTH(8), .SS_INDEX(3), .SYNC_STAGES(SYNC)) u_dut (
    .wb_clk_in(clk), .wb_rst_in(rst_n), .sclk_in(sclk), .mosi_in(mosi), .ss_pad_in(ss),
    .miso_out(miso_out), .miso_oe(miso_oe), .cfg_char_len(cfg_char_len), .cfg_lsb(cfg_lsb),
    .cfg_tx_neg(cfg_tx_neg), .cfg_rx_neg(cfg_rx_neg), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Consumer-side monitor: record accepted RX words and count status pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) obs_q.push_back(rx_data);
      if (underrun) n_under = n_under + 1;
      if (overrun) n_over = n_over + 1;
    end
  end

  // Behavioural master: nbits of a len-bit character; miso sampled just before the slave's rx edge
  task automatic spi_char(input int len, input int nbits, input logic lsb, input logic rx_neg,
                          input logic [31:0] mosi_w, output logic [31:0] miso_w,
                          output logic [31:0] miso_seq);
    int b;
    miso_w = 32'h0;
    miso_seq = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      b = lsb ? i : (len - 1 - i);
      if (!rx_neg) begin
        mosi = mosi_w[b];
        repeat (H) @(negedge clk);
        miso_w[b] = miso_out;
        miso_seq[i] = miso_out;
        sclk = 1'b1;
        repeat (H) @(negedge clk);
        sclk = 1'b0;
      end else begin
        sclk = 1'b1;
        mosi = mosi_w[b];
        repeat (H) @(negedge clk);
        miso_w[b] = miso_out;
        miso_seq[i] = miso_out;
        sclk = 1'b0;
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic push_tx(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        tx_data = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    for (int i = 0; i < 200 && obs_q.size() < n; i++) @(negedge clk);
    ok = (obs_q.size() >= n);
  endtask

  task automatic select_slave();
    ss = 8'hF7;
    repeat (10) @(negedge clk);
  endtask

  task automatic deselect_slave();
    ss = 8'hFF;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] m, s;
    bit ok;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({miso_out, miso_oe, tx_ready, rx_valid, overrun, underrun, busy} !== 7'b0010000) begin
      n_err++;
      $display("FAIL reset_flags: got %b, required 0010000",
               {miso_out, miso_oe, tx_ready, rx_valid, overrun, underrun, busy});
    end
    n_cmp++;
    if (rx_data !== 32'h0) begin n_err++; $display("FAIL reset_rx_data: got %h, required 0", rx_data); end
    rst_n = 1'b1;
    @(negedge clk);
    // One full character left unread, then a partial one cut by reset
    cfg_char_len = 5'd4; cfg_lsb = 1'b1; cfg_tx_neg = 1'b0; cfg_rx_neg = 1'b1; rx_ready = 1'b0;
    select_slave();
    spi_char(4, 4, 1'b1, 1'b1, 32'h9, m, s);
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({rx_valid, rx_data} !== {1'b1, 32'h9}) begin
      n_err++; $display("FAIL pre_reset_rx: got valid=%b data=%h, required 1/00000009", rx_valid, rx_data);
    end
    push_tx(32'h77, ok);
    spi_char(4, 2, 1'b1, 1'b1, 32'h6, m, s);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({miso_out, miso_oe, tx_ready, rx_valid, overrun, underrun, busy} !== 7'b0010000) begin
      n_err++;
      $display("FAIL midreset_flags: got %b, required 0010000",
               {miso_out, miso_oe, tx_ready, rx_valid, overrun, underrun, busy});
    end
    n_cmp++;
    if (rx_data !== 32'h0) begin n_err++; $display("FAIL midreset_rx_data: got %h, required 0", rx_data); end
    ss = 8'hFF; sclk = 1'b0; rx_ready = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({miso_oe, busy, rx_valid, tx_ready} !== 4'b0001) begin
      n_err++; $display("FAIL post_reset_idle: got %b, required 0001", {miso_oe, busy, rx_valid, tx_ready});
    end
  endtask

  task automatic test_mode_a();
    logic [31:0] m, s, e, o;
    bit ok;
    cfg_char_len = 5'd4; cfg_lsb = 1'b1; cfg_tx_neg = 1'b0; cfg_rx_neg = 1'b1;
    push_tx(32'h5, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL a_tx_push: got timeout, required accept"); end
    exp_q.push_back(32'h0000000F);
    select_slave();
    n_cmp++;
    if ({miso_oe, busy} !== 2'b11) begin n_err++; $display("FAIL a_selected: got %b, required 11", {miso_oe, busy}); end
    spi_char(4, 4, 1'b1, 1'b1, 32'hF, m, s);
    n_cmp++;
    if (m[3:0] !== 4'h5) begin n_err++; $display("FAIL a_miso_word: got %h, required 5", m[3:0]); end
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL a_rx_wait: got %0d words, required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL a_rx_word: got %h, required %h", o, e); end
    end
    n_cmp++;
    if (rx_data !== 32'h0000000F) begin n_err++; $display("FAIL a_rx_data: got %h, required 0000000f", rx_data); end
    deselect_slave();
    n_cmp++;
    if ({miso_oe, busy} !== 2'b00) begin n_err++; $display("FAIL a_deselected: got %b, required 00", {miso_oe, busy}); end
  endtask

  task automatic test_mode_b();
    logic [31:0] m, s, e, o;
    logic [3:0]  exp_seq;
    bit ok;
    exp_seq = 4'b0101;  // time order 1,0,1,0 (index 0 first)
    cfg_char_len = 5'd4; cfg_lsb = 1'b0; cfg_tx_neg = 1'b1; cfg_rx_neg = 1'b0;
    push_tx(32'hA, ok);
    exp_q.push_back(32'h0000000F);
    select_slave();
    spi_char(4, 4, 1'b0, 1'b0, 32'hF, m, s);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (s[i] !== exp_seq[i]) begin n_err++; $display("FAIL b_miso_bit%0d: got %b, required %b", i, s[i], exp_seq[i]); end
    end
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL b_rx_wait: got %0d words, required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL b_rx_word: got %h, required %h", o, e); end
    end
    deselect_slave();
  endtask

  task automatic test_back_to_back();
    logic [31:0] m1, m2, s, e, o;
    bit ok1, ok2, ok3;
    int u0;
    cfg_char_len = 5'd0; cfg_lsb = 1'b0; cfg_tx_neg = 1'b1; cfg_rx_neg = 1'b0;
    u0 = n_under;
    push_tx(32'hCAFEF00D, ok1);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h12345678);
    select_slave();
    push_tx(32'h0BADC0DE, ok2);
    spi_char(32, 32, 1'b0, 1'b0, 32'hDEADBEEF, m1, s);
    // Keep the holding register full for the load that follows the last character
    push_tx(32'h600DF00D, ok3);
    spi_char(32, 32, 1'b0, 1'b0, 32'h12345678, m2, s);
    n_cmp++;
    if ({ok1, ok2, ok3} !== 3'b111) begin n_err++; $display("FAIL b2b_tx_push: got %b, required 111", {ok1, ok2, ok3}); end
    wait_obs(2, ok1);
    n_cmp++;
    if (!ok1) begin
      n_err++; $display("FAIL b2b_rx_wait: got %0d words, required 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL b2b_rx_word%0d: got %h, required %h", i, o, e); end
      end
    end
    n_cmp++;
    if (m1 !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_miso0: got %h, required cafef00d", m1); end
    n_cmp++;
    if (m2 !== 32'h0BADC0DE) begin n_err++; $display("FAIL b2b_miso1: got %h, required 0badc0de", m2); end
    n_cmp++;
    if (n_under - u0 !== 0) begin n_err++; $display("FAIL b2b_underrun: got %0d pulses, required 0", n_under - u0); end
    deselect_slave();
  endtask

  task automatic test_overrun_underrun();
    logic [31:0] m1, m2, s, e, o;
    bit ok;
    int u0, o0;
    cfg_char_len = 5'd8; cfg_lsb = 1'b1; cfg_tx_neg = 1'b0; cfg_rx_neg = 1'b1;
    rx_ready = 1'b0;
    u0 = n_under; o0 = n_over;
    exp_q.push_back(32'h0000003C);
    select_slave();
    n_cmp++;
    if (n_under - u0 !== 1) begin n_err++; $display("FAIL ou_underrun_first: got %0d, required 1", n_under - u0); end
    spi_char(8, 8, 1'b1, 1'b1, 32'h3C, m1, s);
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({rx_valid, rx_data} !== {1'b1, 32'h3C}) begin
      n_err++; $display("FAIL ou_first_word: got valid=%b data=%h, required 1/0000003c", rx_valid, rx_data);
    end
    spi_char(8, 8, 1'b1, 1'b1, 32'hA5, m2, s);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (n_over - o0 !== 1) begin n_err++; $display("FAIL ou_overrun: got %0d pulses, required 1", n_over - o0); end
    n_cmp++;
    if (rx_data !== 32'h3C) begin n_err++; $display("FAIL ou_kept_word: got %h, required 0000003c", rx_data); end
    // One pulse per character started: two full ones plus the one opened after the second
    n_cmp++;
    if (n_under - u0 !== 3) begin n_err++; $display("FAIL ou_underrun_total: got %0d, required 3", n_under - u0); end
    n_cmp++;
    if ({m1[7:0], m2[7:0]} !== 16'h0) begin n_err++; $display("FAIL ou_miso_zero: got %h, required 0000", {m1[7:0], m2[7:0]}); end
    deselect_slave();
    rx_ready = 1'b1;
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL ou_rx_wait: got %0d words, required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL ou_rx_word: got %h, required %h", o, e); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] m, s, e, o;
    bit ok;
    cfg_char_len = 5'd8; cfg_lsb = 1'b1; cfg_tx_neg = 1'b0; cfg_rx_neg = 1'b1;
    rx_ready = 1'b1;
    select_slave();
    push_tx(32'h5A, ok);
    spi_char(8, 3, 1'b1, 1'b1, 32'h81, m, s);
    ss = 8'hFF;
    repeat (SYNC + 1) @(negedge clk);
    n_cmp++;
    if ({miso_oe, busy} !== 2'b00) begin n_err++; $display("FAIL abort_release: got %b, required 00", {miso_oe, busy}); end
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({ok, tx_ready} !== 2'b10) begin n_err++; $display("FAIL abort_tx_pending: got ok/ready %b, required 10", {ok, tx_ready}); end
    n_cmp++;
    if ({rx_valid, obs_q.size() == 0} !== 2'b01) begin
      n_err++; $display("FAIL abort_no_rx: got valid=%b words=%0d, required 0/0", rx_valid, obs_q.size());
    end
    // Pending word goes out on the next clean character
    exp_q.push_back(32'h000000C3);
    select_slave();
    spi_char(8, 8, 1'b1, 1'b1, 32'hC3, m, s);
    n_cmp++;
    if (m[7:0] !== 8'h5A) begin n_err++; $display("FAIL abort_next_miso: got %h, required 5a", m[7:0]); end
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL abort_rx_wait: got %0d words, required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL abort_rx_word: got %h, required %h", o, e); end
    end
    deselect_slave();
  endtask

  // Global time limit
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mode_a();
    test_mode_b();
    test_back_to_back();
    test_overrun_underrun();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
